// File: rtl/clkgate_pkg.sv
// Shared types and helpers for the multi-channel clock-gate controller.
package clkgate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ON   = 2'b01,
    ST_HOLD = 2'b10
  } cg_state_e;

  // Idle counter must hold IDLE_CYC; never narrower than one bit.
  function automatic int cnt_width(input int idle_cyc);
    int w;
    w = $clog2(idle_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clkgate_latch_cell.sv
// Glitch-free gate: low-transparent latch on (E | SE) ANDed with the source clock.
module clkgate_latch_cell (
  input  logic CK,
  input  logic E,
  input  logic SE,
  output logic GCK
);

  logic q;

  // Q may only move while CK is low, so GCK can never be truncated mid-pulse.
  always_latch begin
    if (!CK) q <= E | SE;
  end

  assign GCK = CK & q;

endmodule

// File: rtl/clkgate_ctrl_multi.sv
// N_CH request-driven clock gates, each with an idle-hysteresis FSM and a shared scan override.
module clkgate_ctrl_multi
  import clkgate_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IDLE_CYC = 3
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              SE,
  input  logic [N_CH-1:0]   REQ,
  output logic [N_CH-1:0]   GCK,
  output logic [N_CH-1:0]   ACTIVE,
  output logic              ALL_IDLE,
  output logic [2*N_CH-1:0] DBG_STATE
);

  localparam int CNT_W = cnt_width(IDLE_CYC);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC);

  cg_state_e        state_q [N_CH];
  cg_state_e        state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  en_q;
  logic [N_CH-1:0]  en_d;
  logic             all_idle_q;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (REQ[i]) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (!REQ[i]) begin
            if (IDLE_CYC == 0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = IDLE_LD;
            end
          end
        end
        ST_HOLD: begin
          // Counting stops at 1 so a stray zero can never wrap into a long hold.
          if (REQ[i])                          state_d[i] = ST_ON;
          else if (cnt_q[i] <= CNT_W'(1))      state_d[i] = ST_OFF;
          else                                 cnt_d[i]   = cnt_q[i] - CNT_W'(1);
        end
        default: state_d[i] = ST_OFF;
      endcase
      en_d[i] = (state_d[i] != ST_OFF);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      en_q       <= '0;
      all_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      all_idle_q <= ~|en_d;
    end
  end

  assign ACTIVE   = en_q;
  assign ALL_IDLE = all_idle_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign DBG_STATE[2*g +: 2] = state_q[g];

    clkgate_latch_cell u_cell (
      .CK (CK),
      .E  (en_q[g]),
      .SE (SE),
      .GCK(GCK[g])
    );
  end

endmodule

// File: tb/tb_clkgate_ctrl_multi.sv
// Bench for clkgate_ctrl_multi: directed vector table, corner sequences and randomized run against an age-based model.
module tb_clkgate_ctrl_multi;

  localparam int BIG = 1000;

  logic       CK;
  logic       rst_drv;
  logic       se_drv;
  logic [3:0] req_drv;

  logic [3:0] gck_a, active_a, gck_b, active_b;
  logic       idle_a, idle_b;
  logic [7:0] dbg_a, dbg_b;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  clkgate_ctrl_multi #(.N_CH(4), .IDLE_CYC(3)) dut_a (
    .CK(CK), .RST(rst_drv), .SE(se_drv), .REQ(req_drv),
    .GCK(gck_a), .ACTIVE(active_a), .ALL_IDLE(idle_a), .DBG_STATE(dbg_a)
  );

  clkgate_ctrl_multi #(.N_CH(4), .IDLE_CYC(0)) dut_b (
    .CK(CK), .RST(rst_drv), .SE(se_drv), .REQ(req_drv),
    .GCK(gck_b), .ACTIVE(active_b), .ALL_IDLE(idle_b), .DBG_STATE(dbg_b)
  );

  // Reference model: a channel is enabled while fewer than IDLE_CYC+1 cycles
  // have passed since REQ was last sampled high (reset forgets all requests).
  int         age [2][4];
  int         idle_of [2];
  logic [3:0] en_exp [2];
  bit         known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs, advance one posedge, check both instances against the model
  task automatic step(input logic rst, input logic se, input logic [3:0] req);
    logic [3:0] exp_g [2];
    rst_drv = rst;
    se_drv  = se;
    req_drv = req;
    @(posedge CK);
    #1;
    for (int m = 0; m < 2; m++) begin
      exp_g[m] = en_exp[m] | {4{se}};
      for (int c = 0; c < 4; c++) begin
        if (rst)              age[m][c] = BIG;
        else if (req[c])      age[m][c] = 0;
        else if (age[m][c] < BIG) age[m][c]++;
        en_exp[m][c] = (age[m][c] <= idle_of[m]);
      end
    end
    if (known) begin
      check("model_gck_a", 32'(gck_a), 32'(exp_g[0]));
      check("model_gck_b", 32'(gck_b), 32'(exp_g[1]));
    end
    check("model_active_a", 32'(active_a), 32'(en_exp[0]));
    check("model_active_b", 32'(active_b), 32'(en_exp[1]));
    check("model_all_idle_a", 32'(idle_a), 32'(en_exp[0] == 4'h0));
    check("model_all_idle_b", 32'(idle_b), 32'(en_exp[1] == 4'h0));
    if (rst) known = 1'b1;
  endtask

  typedef struct {
    logic       rst;
    logic       se;
    logic [3:0] req;
    logic [3:0] act;
    logic       idle;
    logic [3:0] gck;
    logic       chk_gck;
  } vec_t;

  vec_t tbl [25];
  logic [3:0] req_cur;

  initial begin
    for (int m = 0; m < 2; m++) begin
      en_exp[m] = 4'h0;
      for (int c = 0; c < 4; c++) age[m][c] = BIG;
    end
    idle_of[0] = 3;
    idle_of[1] = 0;
    known   = 1'b0;
    rst_drv = 1'b1;
    se_drv  = 1'b0;
    req_drv = 4'hF;

    //             rst   se    req   act   idle  gck   chk
    tbl[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'h2, 4'h2, 1'b0, 4'h0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'h2, 4'h2, 1'b0, 4'h2, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 4'h2, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 4'h2, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 4'h2, 4'h2, 1'b0, 4'h2, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 4'h2, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 4'h0, 4'h2, 1'b0, 4'hF, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 4'h0, 4'h2, 1'b0, 4'hF, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 4'h4, 4'h4, 1'b0, 4'h0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 4'h4, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 4'h4, 1'b1};
    tbl[23] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h4, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rst, tbl[i].se, tbl[i].req);
      check("tbl_active", 32'(active_a), 32'(tbl[i].act));
      check("tbl_all_idle", 32'(idle_a), 32'(tbl[i].idle));
      if (tbl[i].chk_gck) check("tbl_gck", 32'(gck_a), 32'(tbl[i].gck));
    end

    // Re-request inside HOLD: state goes HOLD then straight back to ON.
    step(1'b0, 1'b0, 4'h2);
    step(1'b0, 1'b0, 4'h0);
    check("hold_state", 32'(dbg_a[3:2]), 32'(2'b10));
    step(1'b0, 1'b0, 4'h2);
    check("rereq_state", 32'(dbg_a[3:2]), 32'(2'b01));
    check("rereq_gck", 32'(gck_a[1]), 32'(1'b1));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0);

    // SE dropping while CK is high must not clip the pulse in flight.
    step(1'b0, 1'b1, 4'h0);
    se_drv = 1'b0;
    #2;
    check("se_fall_hold_a", 32'(gck_a), 32'(4'hF));
    check("se_fall_hold_b", 32'(gck_b), 32'(4'hF));
    @(negedge CK);
    #1;
    check("se_fall_low_a", 32'(gck_a), 32'(4'h0));
    step(1'b0, 1'b0, 4'h0);
    check("se_off_gck", 32'(gck_a), 32'(4'h0));

    // No-hysteresis build: one-cycle request gives exactly one pulse.
    step(1'b0, 1'b0, 4'h8);
    check("idle0_active", 32'(active_b[3]), 32'(1'b1));
    step(1'b0, 1'b0, 4'h0);
    check("idle0_pulse", 32'(gck_b[3]), 32'(1'b1));
    check("idle0_off", 32'(active_b[3]), 32'(1'b0));
    step(1'b0, 1'b0, 4'h0);
    check("idle0_single", 32'(gck_b[3]), 32'(1'b0));

    // Randomized traffic with occasional reset and scan enable.
    req_cur = 4'h0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) == 0) req_cur[c] = ~req_cur[c];
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 29) == 0) ? 4'($urandom) : req_cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
